// File: rtl/systola_pkg.sv
// Shared types and default sizing for the systolic array operand feeders.
package systola_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } feed_state_t;

  localparam int ROWS_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int MAX_K_DEF = 16;

endpackage

// File: rtl/act_skew_feeder_if.sv
// Activation vector input channel of the skew feeder.
// Handshake: a vector transfers on a rising clk edge where in_valid && in_ready; in_vec is held while in_valid waits for in_ready.
interface act_skew_feeder_if #(
  parameter int ROWS = 4,
  parameter int DW   = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_vec;

  modport master (output in_valid, output in_vec, input in_ready);
  modport slave  (input in_valid, input in_vec, output in_ready);
endinterface

// File: rtl/skew_line.sv
// DEPTH-stage shift of {valid, data} with async clear; DEPTH=0 is a wire.
module skew_line #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
  end else begin : g_shift
    logic [DW:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= {in_valid, in_data};
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign {out_valid, out_data} = stage[DEPTH-1];
  end

endmodule

// File: rtl/act_skew_feeder.sv
// West-edge activation feeder: accepts k_len vectors, skews lane r by r cycles,
// flushes the skew pipe and then pulses done.
module act_skew_feeder
  import systola_pkg::*;
#(
  parameter  int ROWS  = ROWS_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int MAX_K = MAX_K_DEF,
  localparam int KW    = $clog2(MAX_K + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  act_skew_feeder_if.slave    up,
  output logic [ROWS*DW-1:0]  out_a,
  output logic [ROWS-1:0]     out_fire,
  output logic                busy,
  output logic                done,
  output feed_state_t         dbg_state
);

  localparam int FW         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_LAST = (ROWS > 1) ? ROWS - 2 : 0;

  feed_state_t        state, state_nxt;
  logic [KW-1:0]      k_reg, acc_cnt;
  logic [FW-1:0]      flush_cnt;
  logic               accept, last_acc, done_set;
  logic               ent_fire;
  logic [ROWS*DW-1:0] ent_vec;

  assign accept    = up.in_valid && (state == S_FEED);
  assign last_acc  = ((acc_cnt + KW'(1)) == k_reg);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (k_len == '0) ? S_DONE : S_FEED;
      S_FEED:  if (accept && last_acc) state_nxt = (ROWS > 1) ? S_FLUSH : S_DONE;
      S_FLUSH: if (flush_cnt == FW'(FLUSH_LAST)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    up.in_ready = (state == S_FEED);
    busy        = (state != S_IDLE);
    done_set    = (state == S_DONE);
  end

  // done is registered one cycle behind S_DONE so it lands after the last row-(ROWS-1) fire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done      <= 1'b0;
      k_reg     <= '0;
      acc_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      done <= done_set;
      if (state == S_IDLE && start) begin
        k_reg   <= k_len;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + KW'(1);
      end
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + FW'(1) : '0;
    end
  end

  // Bubbles enter as fire=0 with zeroed data so out_a is 0 whenever fire is 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_fire <= 1'b0;
      ent_vec  <= '0;
    end else begin
      ent_fire <= accept;
      ent_vec  <= accept ? up.in_vec : '0;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_line #(.DW(DW), .DEPTH(r)) u_line (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (ent_fire),
      .in_data   (ent_vec[r*DW +: DW]),
      .out_valid (out_fire[r]),
      .out_data  (out_a[r*DW +: DW])
    );
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder: per-row expected fire queues plus a done queue.
module tb_act_skew_feeder;
  import systola_pkg::*;

  localparam int ROWS  = 4;
  localparam int DW    = 8;
  localparam int MAX_K = 16;
  localparam int KW    = $clog2(MAX_K + 1);
  localparam int W     = 32 + DW;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic [ROWS*DW-1:0] out_a;
  logic [ROWS-1:0]    out_fire;
  logic               busy, done;
  feed_state_t        dbg_state;

  act_skew_feeder_if #(.ROWS(ROWS), .DW(DW)) up_if ();

  act_skew_feeder #(.ROWS(ROWS), .DW(DW), .MAX_K(MAX_K)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .k_len     (k_len),
    .up        (up_if),
    .out_a     (out_a),
    .out_fire  (out_fire),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0]  exp_q [ROWS][$];
  logic [31:0]   done_q[$];
  int            fire_cnt [ROWS];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] mon_a;
  logic [W-1:0]  mon_e;
  logic [31:0]   mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every fire and done must match the head of its queue
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      for (int r = 0; r < ROWS; r++) begin
        mon_a = out_a[r*DW +: DW];
        if (out_fire[r]) begin
          fire_cnt[r]++;
          if (exp_q[r].size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL row%0d_fire: unexpected fire at cycle %0d data %0h, none required", r, cyc, mon_a);
          end else begin
            mon_e = exp_q[r].pop_front();
            n_cmp++;
            if (mon_e !== {32'(cyc), mon_a}) begin
              n_err++;
              $display("FAIL row%0d_fire: got cycle %0d data %0h, want cycle %0d data %0h",
                       r, cyc, mon_a, mon_e[W-1:DW], mon_e[DW-1:0]);
            end
          end
        end else begin
          check($sformatf("row%0d_idle_a", r), 32'(mon_a), 32'd0);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done: unexpected pulse at cycle %0d, none required", cyc);
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", 32'(cyc), mon_d);
        end
      end
    end
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROWS*DW-1:0] make_vec(input int idx);
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(idx * ROWS + r + 1);
    return v;
  endfunction

  function automatic bit pending();
    bit p;
    p = (done_q.size() != 0);
    for (int r = 0; r < ROWS; r++) if (exp_q[r].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic clear_q();
    done_q.delete();
    for (int r = 0; r < ROWS; r++) exp_q[r].delete();
  endtask

  task automatic clear_cnt();
    for (int r = 0; r < ROWS; r++) fire_cnt[r] = 0;
  endtask

  task automatic check_cnt(input string name, input int k);
    for (int r = 0; r < ROWS; r++) check($sformatf("%s_row%0d_fires", name, r), 32'(fire_cnt[r]), 32'(k));
  endtask

  // Starts a job and feeds k vectors; called right after a posedge (#1).
  task automatic run_job(input int k, input int base, input int bubble_slot,
                         input int mid_start_slot, output int done_cyc);
    int acc  = 0;
    int slot = 0;
    int last = 0;
    logic [ROWS*DW-1:0] v;
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
    k_len = KW'(7);
    if (k == 0) begin
      done_cyc = cyc + 1;
      done_q.push_back(32'(done_cyc));
      return;
    end
    while (acc < k && slot < k + 8) begin
      up_if.in_valid = (slot != bubble_slot);
      up_if.in_vec   = up_if.in_valid ? make_vec(base + acc) : '1;
      start          = (slot == mid_start_slot);
      k_len          = (slot == mid_start_slot) ? KW'(1) : KW'(7);
      @(negedge clk);
      if (up_if.in_valid && up_if.in_ready) begin
        v = make_vec(base + acc);
        for (int r = 0; r < ROWS; r++) exp_q[r].push_back({32'(cyc + 1 + r), v[r*DW +: DW]});
        last = cyc;
        acc++;
      end
      tick();
      slot++;
    end
    up_if.in_valid = 1'b0;
    up_if.in_vec   = '0;
    start          = 1'b0;
    check("accept_count", 32'(acc), 32'(k));
    done_cyc = last + ROWS + 1;
    done_q.push_back(32'(done_cyc));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (pending() && n < 60) begin
      tick();
      n++;
    end
    check("drain_pending", {31'd0, pending()}, 32'd0);
    clear_q();
    tick();
    tick();
  endtask

  task automatic check_quiet(input string name);
    check({name, "_fire"},  32'(out_fire), 32'd0);
    check({name, "_a"},     32'(out_a),    32'd0);
    check({name, "_busy"},  32'(busy),     32'd0);
    check({name, "_done"},  32'(done),     32'd0);
    check({name, "_ready"}, 32'(up_if.in_ready), 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, d2;
    up_if.in_valid = 1'b0;
    up_if.in_vec   = '0;
    clear_cnt();
    // clock/reset
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1 check_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // 1: steady stream, k=3, vectors 0x01..0x0C
    clear_cnt();
    run_job(3, 0, -1, -1, d);
    wait_drain();
    check_cnt("t1", 3);

    // 2: bubble in the second feed slot
    clear_cnt();
    run_job(3, 3, 1, -1, d);
    wait_drain();
    check_cnt("t2", 3);

    // 3: k_len = 0 -> busy for one cycle, done the next, no fires
    clear_cnt();
    run_job(0, 0, -1, -1, d);
    check("t3_busy_c1", 32'(busy), 32'd1);
    tick();
    check("t3_busy_c2", 32'(busy), 32'd0);
    wait_drain();
    check_cnt("t3", 0);

    // 4: start re-asserted in FEED (k_len=1) and in FLUSH (k_len=2) is ignored
    clear_cnt();
    run_job(3, 6, -1, 1, d);
    start = 1'b1;
    k_len = KW'(2);
    tick();
    start = 1'b0;
    wait_drain();
    check_cnt("t4", 3);

    // 5: reset in the middle of FLUSH, then a full MAX_K job
    run_job(3, 9, -1, -1, d);
    tick();
    rstn = 1'b0;
    clear_q();
    #1 check_quiet("t5_rst");
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tick();
    clear_cnt();
    run_job(MAX_K, 0, -1, -1, d);
    wait_drain();
    check_cnt("t5", MAX_K);

    // 6: second job started in the cycle after done
    clear_cnt();
    run_job(3, 40, -1, -1, d);
    while (cyc < d) tick();
    tick();
    run_job(2, 50, -1, -1, d2);
    wait_drain();
    check_cnt("t6", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
